rv32m_div_unit: RTL

- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside the core's ALU in the execute stage and is consumed by it: the core raises start, stalls its PC and writeback while busy, and writes result to rd on the done pulse.
- Replaces a combinational divider that would set the core's critical path.

---
 rtl/rv32m_div_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes; signs are reapplied in FIX.
// Divide-by-zero and signed overflow skip iteration and go straight to FIX.
//
// state | meaning
// IDLE  | waiting for start; operands, op and sign flags latched on accept
// CALC  | one shift/trial-subtract iteration per cycle, XLEN cycles
// FIX   | sign fix-up, quotient/remainder select, done pulse
module rv32m_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic            neg_q;
   logic            neg_r;
   logic            sel_rem;

   logic            is_signed;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            ovf;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   // Operand conditioning and the single iteration datapath.
   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & dividend[XLEN-1];
      b_neg     = is_signed & divisor[XLEN-1];
      // Negating 0x80000000 yields 0x80000000, which is 2^31 read unsigned.
      a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
      b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
      div_zero  = (divisor == '0);
      ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
      // Partial remainder stays below the divisor, so shifted - dvs lies in
      // (-2^XLEN, 2^XLEN) and the XLEN+1-bit difference's MSB is its sign.
      shifted   = {rem, quo[XLEN-1]};
      diff      = shifted - {1'b0, dvs};
      q_fix     = neg_q ? (~quo + 1'b1) : quo;
      r_fix     = neg_r ? (~rem + 1'b1) : rem;
   end

   // Control FSM with registered busy/done/result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         sel_rem <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sel_rem <= op[1];
                  cnt     <= '0;
                  busy    <= 1'b1;
                  if (div_zero) begin
                     quo   <= '1;
                     rem   <= dividend;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= FIX;
                  end else if (ovf) begin
                     quo   <= dividend;
                     rem   <= '0;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= FIX;
                  end else begin
                     quo   <= a_mag;
                     rem   <= '0;
                     dvs   <= b_mag;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               quo <= {quo[XLEN-2:0], ~diff[XLEN]};
               rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN - 1)) state <= FIX;
            end
            FIX: begin
               result <= sel_rem ? r_fix : q_fix;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
